// File: rtl/neuron_job_sequencer.sv
// Job sequencer: buffers 96-bit job descriptors and replays each one to the NeuroSpider core as
// six register writes, a start pulse and a wait for completion. NS_SEQ_TIMEOUT_EN adds a watchdog.
module neuron_job_sequencer #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [95:0] job_data,
  output logic        WE,
  output logic [15:0] Address,
  output logic [15:0] DataWrite,
  output logic        StartOperation,
  input  logic        ReadyNextOperation,
  output logic        busy,
  output logic [15:0] jobs_done,
  output logic        err
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [3:0] {
    StIdle, StWIn, StWWt, StWIdx, StWDest, StWNops, StWCtrl, StStart, StHold, StWait
  } state_e;

  state_e        state_q, state_d;
  logic [95:0]   job_q, job_d;
  logic          hold_q, hold_d;
  logic [15:0]   jobs_done_q, jobs_done_d;
  logic          err_q, err_d;

  logic [95:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ready_en_q;
  logic          fifo_full, fifo_empty, push, pop;
  logic [95:0]   head;

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  // ready_en_q keeps job_ready low for the cycle right after any reset edge
  assign job_ready  = ready_en_q & ~fifo_full;
  assign push       = job_valid & job_ready;
  assign pop        = (state_q == StIdle) & ~fifo_empty;
  assign head       = fifo_mem[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= job_data;
    end
  end

`ifdef NS_SEQ_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    job_d       = job_q;
    hold_d      = hold_q;
    jobs_done_d = jobs_done_q;
    err_d       = err_q;
`ifdef NS_SEQ_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          job_d = head;
          // an empty job is dropped on the spot: flag it and stay idle
          if (head[79:64] == 16'h0000) begin
            err_d = 1'b1;
          end else begin
            state_d = StWIn;
          end
        end
      end
      StWIn:   state_d = StWWt;
      StWWt:   state_d = StWIdx;
      StWIdx:  state_d = StWDest;
      StWDest: state_d = StWNops;
      StWNops: state_d = StWCtrl;
      StWCtrl: state_d = StStart;
      StStart: begin
        state_d = StHold;
        hold_d  = 1'b0;
      end
      StHold: begin
        if (hold_q) begin
          state_d = StWait;
`ifdef NS_SEQ_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end else begin
          hold_d = 1'b1;
        end
      end
      StWait: begin
        if (ReadyNextOperation) begin
          jobs_done_d = jobs_done_q + 16'd1;
          state_d     = StIdle;
        end
`ifdef NS_SEQ_TIMEOUT_EN
        else if (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      job_q       <= '0;
      hold_q      <= 1'b0;
      jobs_done_q <= '0;
      err_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_en_q  <= 1'b0;
`ifdef NS_SEQ_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      job_q       <= job_d;
      hold_q      <= hold_d;
      jobs_done_q <= jobs_done_d;
      err_q       <= err_d;
      count_q     <= count_d;
      ready_en_q  <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
`ifdef NS_SEQ_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  always_comb begin
    WE        = 1'b0;
    Address   = 16'h0000;
    DataWrite = 16'h0000;
    unique case (state_q)
      StWIn:   begin WE = 1'b1; Address = 16'h8000; DataWrite = job_q[15:0];  end
      StWWt:   begin WE = 1'b1; Address = 16'h8006; DataWrite = job_q[31:16]; end
      StWIdx:  begin WE = 1'b1; Address = 16'h8005; DataWrite = job_q[47:32]; end
      StWDest: begin WE = 1'b1; Address = 16'h8001; DataWrite = job_q[63:48]; end
      StWNops: begin WE = 1'b1; Address = 16'h8002; DataWrite = job_q[79:64]; end
      StWCtrl: begin WE = 1'b1; Address = 16'h8004; DataWrite = job_q[95:80]; end
      default: ;
    endcase
  end

  assign StartOperation = (state_q == StStart);
  assign busy           = (state_q != StIdle);
  assign jobs_done      = jobs_done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_neuron_job_sequencer.sv
// Self-checking bench for neuron_job_sequencer: write scoreboard fed at job acceptance,
// core model answering StartOperation, scenario tasks called in sequence.
module tb_neuron_job_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [95:0] job_data = '0;
  logic        WE;
  logic [15:0] Address;
  logic [15:0] DataWrite;
  logic        StartOperation;
  logic        ReadyNextOperation = 1'b1;
  logic        busy;
  logic [15:0] jobs_done;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q [$];
  int          starts_seen = 0;
  int          core_delay  = 5;
  bit          core_stall  = 1'b0;
  bit          abort_mode  = 1'b0;
  int          core_cnt    = 0;
  int          run         = 0;
  logic [15:0] exp_done    = 16'h0000;

  always #5 clk = ~clk;

  neuron_job_sequencer #(
    .FIFO_DEPTH    (4),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .job_valid         (job_valid),
    .job_ready         (job_ready),
    .job_data          (job_data),
    .WE                (WE),
    .Address           (Address),
    .DataWrite         (DataWrite),
    .StartOperation    (StartOperation),
    .ReadyNextOperation(ReadyNextOperation),
    .busy              (busy),
    .jobs_done         (jobs_done),
    .err               (err)
  );

  // Core model: drops Ready on a start pulse, raises it core_delay cycles later unless stalled
  always @(negedge clk) begin
    if (StartOperation) begin
      ReadyNextOperation = 1'b0;
      core_cnt = core_delay;
    end else begin
      if (core_cnt > 0) core_cnt = core_cnt - 1;
      if (core_cnt == 0 && !core_stall) ReadyNextOperation = 1'b1;
    end
  end

  // Write monitor: scoreboard compare, bus invariants, burst length
  always @(negedge clk) begin
    logic [31:0] e;
    bit ok;
    n_tests++;
    if ((!WE && (Address !== 16'h0 || DataWrite !== 16'h0)) || (WE && StartOperation)) begin
      n_fail++;
      $display("FAIL bus_idle: WE=%b Start=%b Address=%h DataWrite=%h, required zero bus when WE=0",
               WE, StartOperation, Address, DataWrite);
    end
    if (StartOperation) starts_seen++;
    if (WE) begin
      run++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got %h/%h, required no write", Address, DataWrite);
      end else begin
        e = exp_q.pop_front();
        if ({Address, DataWrite} !== e) begin
          n_fail++;
          $display("FAIL write_order: got %h/%h, required %h/%h",
                   Address, DataWrite, e[31:16], e[15:0]);
        end
      end
    end else if (run != 0) begin
      n_tests++;
      ok = abort_mode ? (run == 4 && !StartOperation) : (run == 6 && StartOperation);
      if (!ok) begin
        n_fail++;
        $display("FAIL burst: got %0d writes then Start=%b, required %0d writes then Start=%b",
                 run, StartOperation, abort_mode ? 4 : 6, !abort_mode);
      end
      run = 0;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic push_job(input logic [95:0] d);
    int n = 0;
    job_valid = 1'b1;
    job_data  = d;
    while (!job_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: job_ready=%b, required 1 within 200 cycles", job_ready);
    end else if (d[79:64] != 16'h0) begin
      exp_q.push_back({16'h8000, d[15:0]});
      exp_q.push_back({16'h8006, d[31:16]});
      exp_q.push_back({16'h8005, d[47:32]});
      exp_q.push_back({16'h8001, d[63:48]});
      exp_q.push_back({16'h8002, d[79:64]});
      exp_q.push_back({16'h8004, d[95:80]});
    end
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%b pending=%0d, required idle within %0d cycles",
               busy, exp_q.size(), budget);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_done = 16'h0000;
  endtask

  task automatic test_reset();
    do_reset();
    check("reset_ready_low", {31'b0, job_ready}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_we_start", {30'b0, WE, StartOperation}, 32'd0);
    check("reset_jobs_done", {16'b0, jobs_done}, 32'd0);
    check("reset_err", {31'b0, err}, 32'd0);
    @(negedge clk);
    check("ready_after_reset", {31'b0, job_ready}, 32'd1);
  endtask

  task automatic test_single();
    int s0 = starts_seen;
    core_delay = 5;
    push_job({16'h0000, 16'h0002, 16'h0001, 16'h0001, 16'h0001, 16'h0001});
    @(negedge clk);
    check("first_write_latency", {15'b0, WE, Address}, {15'b0, 1'b1, 16'h8000});
    wait_idle(100);
    exp_done = exp_done + 16'd1;
    check("single_jobs_done", {16'b0, jobs_done}, {16'b0, exp_done});
    check("single_starts", starts_seen - s0, 32'd1);
    check("single_busy", {31'b0, busy}, 32'd0);
  endtask

  task automatic test_back_to_back();
    int s0 = starts_seen;
    logic [95:0] d [6];
    for (int i = 0; i < 6; i++) begin
      d[i] = {16'(16'hC000 + i), 16'(i + 1), 16'(16'hD0 + i), 16'(16'h30 + i),
              16'(16'h20 + i), 16'(16'h10 + i)};
    end
    core_stall = 1'b1;
    for (int i = 0; i < 4; i++) push_job(d[i]);
    check("ready_occ3", {31'b0, job_ready}, 32'd1);
    push_job(d[4]);
    check("ready_full", {31'b0, job_ready}, 32'd0);
    job_valid = 1'b1;
    job_data  = d[5];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("held_while_full", {31'b0, job_ready}, 32'd0);
    end
    core_stall = 1'b0;
    push_job(d[5]);
    wait_idle(600);
    exp_done = exp_done + 16'd6;
    check("b2b_jobs_done", {16'b0, jobs_done}, {16'b0, exp_done});
    check("b2b_starts", starts_seen - s0, 32'd6);
    check("b2b_err", {31'b0, err}, 32'd0);
  endtask

  task automatic test_zero_ops();
    int s0 = starts_seen;
    push_job({16'h0055, 16'h0000, 16'h00AA, 16'h00BB, 16'h00CC, 16'h00DD});
    @(negedge clk);
    check("zero_err", {31'b0, err}, 32'd1);
    check("zero_idle", {30'b0, busy, WE}, 32'd0);
    push_job({16'h0077, 16'h0003, 16'h0044, 16'h0033, 16'h0022, 16'h0011});
    wait_idle(100);
    exp_done = exp_done + 16'd1;
    check("zero_jobs_done", {16'b0, jobs_done}, {16'b0, exp_done});
    check("zero_starts", starts_seen - s0, 32'd1);
    check("zero_err_sticky", {31'b0, err}, 32'd1);
  endtask

  task automatic test_reset_mid();
    int s0;
    int n = 0;
    do_reset();
    @(negedge clk);
    s0 = starts_seen;
    push_job({16'h0009, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0006});
    while (!(WE && Address == 16'h8001) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reach_w_dest", {31'b0, WE}, 32'd1);
    abort_mode = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_we", {31'b0, WE}, 32'd0);
    rst_n = 1'b1;
    exp_q.delete();
    exp_done = 16'h0000;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) n++;
    end
    abort_mode = 1'b0;
    check("abort_no_start", starts_seen - s0, 32'd0);
    check("abort_jobs_done", {16'b0, jobs_done}, 32'd0);
    check("abort_fifo_empty", {31'b0, busy}, 32'd0);
    check("abort_err", {31'b0, err}, 32'd0);
  endtask

  task automatic test_timeout();
    int n = 0;
    core_stall = 1'b1;
    push_job({16'h0001, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005});
    while (!StartOperation && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("timeout_start_seen", {31'b0, StartOperation}, 32'd1);
`ifdef NS_SEQ_TIMEOUT_EN
    repeat (12) @(negedge clk);
    check("timeout_last_wait", {30'b0, busy, err}, 32'd2);
    @(negedge clk);
    check("timeout_fired", {30'b0, busy, err}, 32'd1);
    check("timeout_jobs_done", {16'b0, jobs_done}, {16'b0, exp_done});
    core_stall = 1'b0;
`else
    repeat (300) @(negedge clk);
    check("no_timeout_busy", {30'b0, busy, err}, 32'd2);
    check("no_timeout_jobs_done", {16'b0, jobs_done}, {16'b0, exp_done});
    core_stall = 1'b0;
    wait_idle(50);
    exp_done = exp_done + 16'd1;
    check("late_ready_done", {16'b0, jobs_done}, {16'b0, exp_done});
`endif
    wait_idle(50);
  endtask

  task automatic test_wrap();
    force dut.jobs_done_q = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    release dut.jobs_done_q;
    @(negedge clk);
    check("preload_ffff", {16'b0, jobs_done}, 32'h0000_FFFF);
    core_delay = 2;
    push_job({16'h0123, 16'h0001, 16'h0456, 16'h0789, 16'h0ABC, 16'h0DEF});
    wait_idle(100);
    check("jobs_done_wrap", {16'b0, jobs_done}, 32'd0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_zero_ops();
    test_reset_mid();
    test_timeout();
    test_wrap();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
